// File: rtl/axi_sram_if.sv
// AXI4 bus bundle between an AXI master and the SRAM slave endpoint.
// Both the write channels and the read channels are carried here; the clock and reset stay outside.
interface axi_sram_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID, AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST, WVALID, WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID, BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID, ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST, RVALID, RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave endpoint that terminates one transaction at a time on a single-port SRAM.
// The SRAM has 1-cycle read latency and byte write enables. Reads win arbitration against writes in IDLE.
module axi_sram_slave #(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  axi_sram_if.slave           axi,
  output logic                sram_cs,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WDATA, WRESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [1:0]         burst_q, burst_d;
  logic               err_q, err_d;
  logic               first_q, first_d;
  logic [DATA_W-1:0]  rhold_q, rhold_d;

  logic [SRAM_AW-1:0] addr_nxt;
  logic               last_beat;

  // Size and the out-of-range address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi.ARSIZE, axi.AWSIZE,
                         axi.ARADDR[ADDR_W-1:SRAM_AW+2], axi.ARADDR[1:0],
                         axi.AWADDR[ADDR_W-1:SRAM_AW+2], axi.AWADDR[1:0]};

  // FIXED holds the address; INCR, WRAP and reserved all step one word.
  assign addr_nxt  = (burst_q == 2'b00) ? addr_q : addr_q + 1'b1;
  assign last_beat = (cnt_q == len_q);

  // Data is live from the SRAM in the first RDATA cycle, then held for stalls.
  assign axi.RDATA = first_q ? sram_rdata : rhold_q;
  assign axi.RID   = id_q;
  assign axi.BID   = id_q;
  assign axi.RRESP = 2'b00;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    err_d       = err_q;
    first_d     = 1'b0;
    rhold_d     = first_q ? sram_rdata : rhold_q;
    axi.ARREADY = 1'b0;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RLAST   = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    sram_cs     = 1'b0;
    sram_we     = '0;
    sram_addr   = addr_q;
    sram_wdata  = axi.WDATA;
    case (state_q)
      IDLE: begin
        axi.ARREADY = 1'b1;
        axi.AWREADY = ~axi.ARVALID;
        if (axi.ARVALID) begin
          id_d    = axi.ARID;
          addr_d  = axi.ARADDR[SRAM_AW+1:2];
          len_d   = axi.ARLEN;
          burst_d = axi.ARBURST;
          cnt_d   = '0;
          state_d = RADDR;
        end else if (axi.AWVALID) begin
          id_d    = axi.AWID;
          addr_d  = axi.AWADDR[SRAM_AW+1:2];
          len_d   = axi.AWLEN;
          burst_d = axi.AWBURST;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = WDATA;
        end
      end
      RADDR: begin
        sram_cs = 1'b1;
        first_d = 1'b1;
        state_d = RDATA;
      end
      RDATA: begin
        axi.RVALID = 1'b1;
        axi.RLAST  = last_beat;
        if (axi.RREADY) begin
          if (last_beat) state_d = IDLE;
          else begin
            cnt_d   = cnt_q + 1'b1;
            addr_d  = addr_nxt;
            state_d = RADDR;
          end
        end
      end
      WDATA: begin
        axi.WREADY = 1'b1;
        if (axi.WVALID) begin
          sram_cs = 1'b1;
          sram_we = axi.WSTRB;
          // Beat count is authoritative; a misplaced WLAST only poisons BRESP.
          if (axi.WLAST != last_beat) err_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_nxt;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        axi.BVALID = 1'b1;
        axi.BRESP  = err_q ? 2'b10 : 2'b00;
        if (axi.BREADY) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      rhold_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      first_q <= first_d;
      rhold_q <= rhold_d;
    end
  end

endmodule
